// File: rtl/pad_matrix_scanner.sv
// pad_matrix_scanner
//   Scans the 3x3 floor-pad grid as a row/column matrix, debounces every pad
//   on a per-frame basis and debounces the separate start button.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-low
//   col_n[2:0] column sense, active-low (0 = pad on driven row pressed)
//   start_n    start button, active-low
//   row_n[2:0] row drive, one-cold
//   box[8:0]   debounced pad map, 1 = pressed, index = row*3 + col
//   box_valid  one-cycle pulse each frame when box has been re-evaluated
//   start_op   one-cycle pulse per debounced start press
module pad_matrix_scanner #(
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned DEB_FRAMES = 4,
  parameter int unsigned START_DEB  = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] col_n,
  input  logic       start_n,
  output logic [2:0] row_n,
  output logic [8:0] box,
  output logic       box_valid,
  output logic       start_op
);

  localparam int unsigned DW = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
  localparam int unsigned CW = (DEB_FRAMES > 1) ? $clog2(DEB_FRAMES) : 1;
  localparam int unsigned SW = (START_DEB  > 1) ? $clog2(START_DEB)  : 1;

  typedef enum logic [1:0] {ROW0, ROW1, ROW2} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [DW-1:0] dwell;
  logic          row_done;
  logic          frame_end;

  logic [2:0]    col_s1;
  logic [2:0]    col_s2;
  logic [2:0]    col_press;
  // Rows 0 and 1 of the raw map are stored; row 2 is consumed directly at
  // the frame-end edge, so it never needs a register of its own.
  logic [5:0]    raw_lo;
  logic [8:0]    raw_frame;
  logic [CW-1:0] cnt [9];

  logic          start_s1;
  logic          start_s2;
  logic          st_press;
  logic          st_level;
  logic          st_level_q;
  logic [SW-1:0] st_cnt;

  assign row_done  = (dwell == DW'(SCAN_DIV - 1));
  assign frame_end = row_done && (state == ROW2);
  assign col_press = ~col_s2;
  assign raw_frame = {col_press, raw_lo};
  assign st_press  = ~start_s2;

  // Scan FSM: state register
  always_ff @(posedge clk) begin
    if (!rst) state <= ROW0;
    else      state <= state_nxt;
  end

  // Scan FSM: next state
  always_comb begin
    state_nxt = state;
    if (row_done) begin
      unique case (state)
        ROW0:    state_nxt = ROW1;
        ROW1:    state_nxt = ROW2;
        default: state_nxt = ROW0;
      endcase
    end
  end

  // Scan FSM: outputs
  always_comb begin
    row_n = 3'b110;
    unique case (state)
      ROW0:    row_n = 3'b110;
      ROW1:    row_n = 3'b101;
      default: row_n = 3'b011;
    endcase
  end

  // Synchronizers, dwell counter and raw capture
  always_ff @(posedge clk) begin
    if (!rst) begin
      col_s1   <= '1;
      col_s2   <= '1;
      start_s1 <= 1'b1;
      start_s2 <= 1'b1;
      dwell    <= '0;
      raw_lo   <= '0;
    end else begin
      col_s1   <= col_n;
      col_s2   <= col_s1;
      start_s1 <= start_n;
      start_s2 <= start_s1;
      if (row_done) begin
        dwell <= '0;
        unique case (state)
          ROW0:    raw_lo[2:0] <= col_press;
          ROW1:    raw_lo[5:3] <= col_press;
          default: ;
        endcase
      end else begin
        dwell <= dwell + DW'(1);
      end
    end
  end

  // Per-pad frame debounce
  always_ff @(posedge clk) begin
    if (!rst) begin
      box       <= '0;
      box_valid <= 1'b0;
      for (int unsigned p = 0; p < 9; p++) cnt[p] <= '0;
    end else begin
      box_valid <= frame_end;
      if (frame_end) begin
        for (int unsigned p = 0; p < 9; p++) begin
          if (raw_frame[p] == box[p]) begin
            cnt[p] <= '0;
          end else if (cnt[p] == CW'(DEB_FRAMES - 1)) begin
            box[p] <= raw_frame[p];
            cnt[p] <= '0;
          end else begin
            cnt[p] <= cnt[p] + CW'(1);
          end
        end
      end
    end
  end

  // Start button debounce; the pulse fires the cycle after the level rises
  always_ff @(posedge clk) begin
    if (!rst) begin
      st_level   <= 1'b0;
      st_level_q <= 1'b0;
      st_cnt     <= '0;
      start_op   <= 1'b0;
    end else begin
      st_level_q <= st_level;
      start_op   <= st_level & ~st_level_q;
      if (st_press != st_level) begin
        if (st_cnt == SW'(START_DEB - 1)) begin
          st_level <= st_press;
          st_cnt   <= '0;
        end else begin
          st_cnt <= st_cnt + SW'(1);
        end
      end else begin
        st_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pad_matrix_scanner.sv
// Scoreboard bench for pad_matrix_scanner (SCAN_DIV=4, DEB_FRAMES=2,
// START_DEB=8, frame = 12 cycles). The pad matrix is modelled from row_n.
module tb_pad_matrix_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] col_n;
  logic       start_n;
  logic [2:0] row_n;
  logic [8:0] box;
  logic       box_valid;
  logic       start_op;

  logic [8:0] pads = '0;
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  bit         skip_stab = 1'b1;
  logic [8:0] prev_box;
  logic [8:0] box_q [$];
  int         st_q [$];

  pad_matrix_scanner #(.SCAN_DIV(4), .DEB_FRAMES(2), .START_DEB(8)) dut (
    .clk(clk), .rst(rst), .col_n(col_n), .start_n(start_n),
    .row_n(row_n), .box(box), .box_valid(box_valid), .start_op(start_op)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pressed pads pull their column low when their row is driven
  always_comb begin
    col_n = 3'b111;
    for (int r = 0; r < 3; r++)
      if (row_n[r] === 1'b0)
        for (int c = 0; c < 3; c++)
          if (pads[3*r+c]) col_n[c] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents an output
  always @(negedge clk) begin
    logic [8:0] eb;
    int         ec;
    if (box_valid === 1'b1) begin
      tests++;
      if (box_q.size() == 0) begin
        fails++;
        $display("FAIL box_unexpected: got box_valid with box=%h, expected no frame", box);
      end else begin
        eb = box_q.pop_front();
        if (box !== eb) begin
          fails++;
          $display("FAIL box_frame: got %h expected %h at cycle %0d", box, eb, cyc);
        end
      end
    end
    if (start_op === 1'b1) begin
      tests++;
      if (st_q.size() == 0) begin
        fails++;
        $display("FAIL start_unexpected: got start_op at cycle %0d, expected none", cyc);
      end else begin
        ec = st_q.pop_front();
        if (cyc != ec) begin
          fails++;
          $display("FAIL start_time: got cycle %0d expected %0d", cyc, ec);
        end
      end
    end
    if (!skip_stab && box_valid !== 1'b1) begin
      tests++;
      if (box !== prev_box) begin
        fails++;
        $display("FAIL box_stable: got %h expected %h (no box_valid)", box, prev_box);
      end
    end
    prev_box = box;
  end

  // One frame: apply pad state, push the hand-computed box, await box_valid
  task automatic frame(input logic [8:0] p, input logic [8:0] e);
    bit seen = 1'b0;
    pads = p;
    box_q.push_back(e);
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (box_valid === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL frame_timeout: got no box_valid in 40 cycles, expected one");
    end
  endtask

  task automatic start_test();
    start_n = 1'b0;                 // short press: rejected
    repeat (5) @(negedge clk);
    start_n = 1'b1;
    repeat (12) @(negedge clk);
    start_n = 1'b0;                 // long press: 2 sync + 8 deb + 1
    st_q.push_back(cyc + 11);
    repeat (20) @(negedge clk);
    start_n = 1'b1;                 // release: no pulse
    repeat (15) @(negedge clk);
  endtask

  initial begin
    logic [2:0] er;
    rst = 1'b0;
    start_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_box", 32'(box), 32'h0);
    check("reset_row_n", 32'(row_n), 32'h6);
    check("reset_box_valid", 32'(box_valid), 32'h0);
    check("reset_start_op", 32'(start_op), 32'h0);
    rst = 1'b1;
    prev_box = box;
    skip_stab = 1'b0;

    // F1: idle frame, row sequence and frame period
    box_q.push_back(9'h000);
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      er = (n < 4) ? 3'b110 : (n < 8) ? 3'b101 : (n < 12) ? 3'b011 : 3'b110;
      check("idle_row_n", 32'(row_n), 32'(er));
      check("idle_box_valid", 32'(box_valid), (n == 12) ? 32'h1 : 32'h0);
    end

    fork
      begin
        frame(9'h000, 9'h000);      // F2 idle
        frame(9'h000, 9'h000);      // F3 idle
        frame(9'h010, 9'h000);      // F4 pad 4 first seen
        frame(9'h010, 9'h010);      // F5 pad 4 accepted
        frame(9'h010, 9'h010);
        frame(9'h010, 9'h010);
      end
      start_test();
    join

    frame(9'h000, 9'h010);          // release, first frame
    frame(9'h000, 9'h000);          // release accepted
    frame(9'h001, 9'h000);          // one-frame bounce on pad 0
    frame(9'h000, 9'h000);
    frame(9'h000, 9'h000);
    frame(9'h001, 9'h000);          // interrupted disagreement restarts count
    frame(9'h000, 9'h000);
    frame(9'h001, 9'h000);
    frame(9'h000, 9'h000);
    frame(9'h111, 9'h000);          // multi-pad
    frame(9'h111, 9'h111);
    frame(9'h111, 9'h111);
    frame(9'h000, 9'h111);
    frame(9'h000, 9'h000);
    frame(9'h010, 9'h000);          // establish pad 4 again
    frame(9'h010, 9'h010);

    // Mid-frame reset during ROW1
    repeat (5) @(negedge clk);
    check("pre_reset_row_n", 32'(row_n), 32'h5);
    skip_stab = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    check("midreset_box", 32'(box), 32'h0);
    check("midreset_row_n", 32'(row_n), 32'h6);
    check("midreset_box_valid", 32'(box_valid), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    skip_stab = 1'b0;
    frame(9'h010, 9'h000);          // re-acquire pad 4
    frame(9'h010, 9'h010);

    repeat (3) @(negedge clk);
    check("box_queue_drained", 32'(box_q.size()), 32'h0);
    check("start_queue_drained", 32'(st_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected end of test");
    $fatal(1, "watchdog");
  end

endmodule
